ysyx_22040237_exu_mc: RTL and testbench

//  Parametrised multi-cycle execute unit; successor to the single-cycle EXU. Sits between IDU and WBU.

---
 rtl/ysyx_22040237_exu_mc.sv | 151 +++++++++++++++
 tb/tb_ysyx_22040237_exu_mc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040237_exu_mc.sv
// ysyx_22040237_exu_mc: multi-cycle execute unit (ALU, iterative MUL, restoring divider when YSYX_22040237_DIV_EN is defined)
module ysyx_22040237_exu_mc #(
  parameter int XLEN = 64,
  parameter int ADDR_W = 32,
  parameter int MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        inst_opcode,
  input  logic              word,
  input  logic [XLEN-1:0]   op1,
  input  logic [XLEN-1:0]   op2,
  input  logic [ADDR_W-1:0] op1_jump,
  input  logic [ADDR_W-1:0] op2_jump,
  input  logic              inst_ebreak,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   rd_data,
  output logic [ADDR_W-1:0] pc_jump_addr,
  output logic              ebreak_req
);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3;
  localparam int MUL_N = XLEN / MUL_STEP;
  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction
  logic [1:0] state;
  logic [7:0] cnt;
  logic [XLEN-1:0] acc, a, b, alu, pp, mul_sum;
  logic [5:0] sh;
  logic op_word, take, is_mul;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign out_valid = state == DONE;
  assign take = in_valid && in_ready;
  assign is_mul = inst_opcode == 8'h10;
  assign sh = (word || XLEN == 32) ? {1'b0, op2[4:0]} : op2[5:0];
  always_comb begin
    case (inst_opcode)
      8'h00: alu = op1 + op2;
      8'h01: alu = op1 - op2;
      8'h02: alu = op1 & op2;
      8'h03: alu = op1 | op2;
      8'h04: alu = op1 ^ op2;
      8'h05: alu = op1 << sh;
      8'h06: alu = (word ? XLEN'(op1[31:0]) : op1) >> sh;
      8'h07: alu = $signed(word ? sx32(op1[31:0]) : op1) >>> sh;
      8'h08: alu = XLEN'($signed(op1) < $signed(op2));
      8'h09: alu = XLEN'(op1 < op2);
      default: alu = '0;
    endcase
    if (word) alu = sx32(alu[31:0]);
  end
  // a holds the shifting multiplicand, b the shifting multiplier, acc the partial product
  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_STEP; j++) pp = pp + (b[j] ? a << j : '0);
    mul_sum = acc + pp;
  end
`ifdef YSYX_22040237_DIV_EN
  localparam logic [1:0] DIV = 2'd2;
  logic op_rem, neg_q, neg_r, dzero, is_div, sgn;
  logic [XLEN-1:0] da, db, q_next, r_next, q_fix, r_fix, div_res;
  logic [XLEN:0] r_sh, diff;
  assign is_div = inst_opcode[7:2] == 6'b000110;
  assign sgn = !inst_opcode[0];
  assign da = word ? (sgn ? sx32(op1[31:0]) : XLEN'(op1[31:0])) : op1;
  assign db = word ? (sgn ? sx32(op2[31:0]) : XLEN'(op2[31:0])) : op2;
  // magnitudes are divided; a shifts dividend bits out and quotient bits in, acc is the remainder
  always_comb begin
    r_sh = {acc, a[XLEN-1]};
    diff = r_sh - {1'b0, b};
    q_next = {a[XLEN-2:0], !diff[XLEN]};
    r_next = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    q_fix = dzero ? '1 : neg_q ? -q_next : q_next;
    r_fix = neg_r ? -r_next : r_next;
    div_res = op_rem ? r_fix : q_fix;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_data <= '0;
      pc_jump_addr <= '0;
      ebreak_req <= 1'b0;
      acc <= '0;
      a <= '0;
      b <= '0;
      cnt <= '0;
      op_word <= 1'b0;
`ifdef YSYX_22040237_DIV_EN
      op_rem <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dzero <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
    end else if (take) begin
      pc_jump_addr <= op1_jump + op2_jump;
      ebreak_req <= inst_ebreak;
      op_word <= word;
      cnt <= '0;
      acc <= '0;
      if (is_mul) begin
        state <= MUL;
        a <= op1;
        b <= op2;
      end
`ifdef YSYX_22040237_DIV_EN
      else if (is_div) begin
        state <= DIV;
        a <= (sgn && da[XLEN-1]) ? -da : da;
        b <= (sgn && db[XLEN-1]) ? -db : db;
        neg_q <= sgn && (da[XLEN-1] ^ db[XLEN-1]);
        neg_r <= sgn && da[XLEN-1];
        dzero <= db == '0;
        op_rem <= inst_opcode[1];
      end
`endif
      else begin
        state <= DONE;
        rd_data <= alu;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end else if (state == MUL) begin
      acc <= mul_sum;
      a <= a << MUL_STEP;
      b <= b >> MUL_STEP;
      cnt <= cnt + 8'd1;
      if (cnt == 8'(MUL_N - 1)) begin
        state <= DONE;
        rd_data <= op_word ? sx32(mul_sum[31:0]) : mul_sum;
      end
    end
`ifdef YSYX_22040237_DIV_EN
    else if (state == DIV) begin
      acc <= r_next;
      a <= q_next;
      cnt <= cnt + 8'd1;
      if (cnt == 8'(XLEN - 1)) begin
        state <= DONE;
        rd_data <= op_word ? sx32(div_res[31:0]) : div_res;
      end
    end
`endif
  end
endmodule

// File: tb/tb_ysyx_22040237_exu_mc.sv
// tb_ysyx_22040237_exu_mc: directed and random checks of the execute unit against an arithmetic reference model
module tb_ysyx_22040237_exu_mc;
  localparam int XLEN = 64, ADDR_W = 32, MUL_STEP = 1;
  localparam int MUL_LAT = XLEN / MUL_STEP + 1;
  logic clk = 0, rst = 1, in_valid = 0, word = 0, inst_ebreak = 0, flush = 0, out_ready = 1;
  logic [7:0] inst_opcode = 0;
  logic [63:0] op1 = 0, op2 = 0;
  logic [31:0] op1_jump = 0, op2_jump = 0;
  logic in_ready, out_valid, ebreak_req;
  logic [63:0] rd_data;
  logic [31:0] pc_jump_addr;
  int n_chk = 0, n_pass = 0;

  ysyx_22040237_exu_mc #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MUL_STEP(MUL_STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_opcode(inst_opcode), .word(word), .op1(op1), .op2(op2),
    .op1_jump(op1_jump), .op2_jump(op2_jump), .inst_ebreak(inst_ebreak),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .rd_data(rd_data), .pc_jump_addr(pc_jump_addr), .ebreak_req(ebreak_req)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [7:0] op, input logic w, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] r, ux, uy;
    logic signed [63:0] sx, sy;
    int sh;
    sh = w ? int'(y[4:0]) : int'(y[5:0]);
    sx = w ? {{32{x[31]}}, x[31:0]} : x;
    sy = w ? {{32{y[31]}}, y[31:0]} : y;
    ux = w ? {32'b0, x[31:0]} : x;
    uy = w ? {32'b0, y[31:0]} : y;
    case (op)
      8'h00: r = x + y;
      8'h01: r = x - y;
      8'h02: r = x & y;
      8'h03: r = x | y;
      8'h04: r = x ^ y;
      8'h05: r = x << sh;
      8'h06: r = ux >> sh;
      8'h07: r = sx >>> sh;
      8'h08: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      8'h09: r = (x < y) ? 64'd1 : 64'd0;
      8'h10: r = x * y;
`ifdef YSYX_22040237_DIV_EN
      8'h18, 8'h1A: begin
        if (sy == 0) r = (op == 8'h18) ? '1 : sx;
        else if (sx == 64'sh8000_0000_0000_0000 && sy == -64'sd1) r = (op == 8'h18) ? sx : 64'd0;
        else r = (op == 8'h18) ? sx / sy : sx % sy;
      end
      8'h19, 8'h1B: begin
        if (uy == 0) r = (op == 8'h19) ? '1 : ux;
        else r = (op == 8'h19) ? ux / uy : ux % uy;
      end
`endif
      default: r = 64'd0;
    endcase
    return w ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  function automatic int exp_lat(input logic [7:0] op);
    if (op == 8'h10) return MUL_LAT;
`ifdef YSYX_22040237_DIV_EN
    if (op >= 8'h18 && op <= 8'h1B) return XLEN + 1;
`endif
    return 1;
  endfunction

  function automatic logic [63:0] rnd();
    case ($urandom_range(0, 4))
      0: return 64'($urandom_range(0, 15));
      1: return -64'($urandom_range(1, 8));
      2: return 64'h8000_0000_0000_0000;
      3: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // present one op, scramble inputs after accept, then check latency and the held result
  task automatic run_op(input string tag, input logic [7:0] op, input logic w, input logic [63:0] x,
                        input logic [63:0] y, input logic [31:0] j1, input logic [31:0] j2, input logic eb);
    int lat;
    logic busy_ready;
    @(negedge clk);
    inst_opcode = op; word = w; op1 = x; op2 = y; op1_jump = j1; op2_jump = j2; inst_ebreak = eb; in_valid = 1;
    lat = 0;
    while (!in_ready && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!in_ready) check({tag, " accept"}, 0, 1);
    @(negedge clk);
    in_valid = 0;
    inst_opcode = 8'($urandom); word = 1'($urandom); op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
    op1_jump = $urandom; op2_jump = $urandom; inst_ebreak = 1'($urandom);
    lat = 1;
    busy_ready = 0;
    while (!out_valid && lat < 300) begin
      busy_ready |= in_ready;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat(op)));
    check({tag, " rd_data"}, rd_data, model(op, w, x, y));
    check({tag, " pc_jump"}, 64'(pc_jump_addr), 64'(32'(j1 + j2)));
    check({tag, " ebreak"}, 64'(ebreak_req), 64'(eb));
    if (lat > 1) check({tag, " busy in_ready"}, 64'(busy_ready), 64'd0);
  endtask

  logic [7:0] ops [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                           8'h08, 8'h09, 8'h10, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h3C};

  initial begin
    logic seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset rd_data", rd_data, 64'd0);
    check("reset pc_jump", 64'(pc_jump_addr), 64'd0);
    check("reset ebreak", 64'(ebreak_req), 64'd0);
    rst = 0;
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);

    inst_opcode = 8'h00; word = 0; op1 = 5; op2 = 7; in_valid = 1; out_ready = 1;
    @(negedge clk);
    check("b2b add valid", 64'(out_valid), 64'd1);
    check("b2b add", rd_data, 64'd12);
    check("b2b in_ready", 64'(in_ready), 64'd1);
    inst_opcode = 8'h01; op1 = 3; op2 = 5;
    @(negedge clk);
    in_valid = 0;
    check("b2b sub valid", 64'(out_valid), 64'd1);
    check("b2b sub", rd_data, 64'hFFFF_FFFF_FFFF_FFFE);

    run_op("mul", 8'h10, 0, 64'h1_0000_0001, 64'd3, 32'h100, 32'h4, 0);
    check("mul value", rd_data, 64'h3_0000_0003);
    run_op("pc wrap", 8'h00, 0, 64'd1, 64'd2, 32'hFFFF_FFF0, 32'h20, 1);
    check("pc wrap value", 64'(pc_jump_addr), 64'h10);
    run_op("sraw", 8'h07, 1, 64'h0000_0000_8000_0000, 64'd36, 0, 0, 0);
    run_op("sll63", 8'h05, 0, 64'd1, 64'd63, 0, 0, 0);
    run_op("unknown", 8'h7F, 0, 64'd9, 64'd9, 0, 0, 0);
    run_op("op18", 8'h18, 0, 64'd100, 64'd7, 0, 0, 0);

    @(negedge clk);
    out_ready = 0;
    inst_opcode = 8'h00; word = 1; op1 = 64'h7FFF_FFFF; op2 = 1; in_valid = 1;
    @(negedge clk);
    in_valid = 0; op1 = 0; word = 0;
    check("addw", rd_data, 64'hFFFF_FFFF_8000_0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold valid", 64'(out_valid), 64'd1);
      check("hold rd_data", rd_data, 64'hFFFF_FFFF_8000_0000);
      check("hold in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    @(negedge clk);
    check("release valid", 64'(out_valid), 64'd0);

`ifdef YSYX_22040237_DIV_EN
    run_op("divu0", 8'h19, 0, 64'd100, 64'd0, 0, 0, 0);
    check("divu0 value", rd_data, '1);
    run_op("rem", 8'h1A, 0, -64'd7, 64'd2, 0, 0, 0);
    check("rem value", rd_data, '1);
    run_op("divovf", 8'h18, 0, 64'h8000_0000_0000_0000, '1, 0, 0, 0);
    check("divovf value", rd_data, 64'h8000_0000_0000_0000);
    run_op("divw", 8'h18, 1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 0);
`endif

    inst_opcode = 8'h00; word = 0; op1 = 1; op2 = 1; flush = 1; in_valid = 1;
    @(negedge clk);
    flush = 0; in_valid = 0;
    check("flush drops accept", 64'(out_valid), 64'd0);

    inst_opcode = 8'h10; op1 = 64'd11; op2 = 64'd13; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush valid", 64'(out_valid), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (MUL_LAT + 5) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("flush no result", 64'(seen), 64'd0);
    run_op("after flush", 8'h00, 0, 64'd20, 64'd22, 32'd8, 32'd8, 0);

    for (int i = 0; i < 150; i++)
      run_op("rand", ops[$urandom_range(0, 15)], 1'($urandom), rnd(), rnd(), $urandom, $urandom, 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
